// File: rtl/logic_analyzer_pkg.sv
// Shared definitions for the logic analyzer: capture FSM state encoding and probe packing order.
// Imported by the capture core, the playback generator and the host register map.
package logic_analyzer_pkg;

  localparam logic [2:0] ST_IDLE             = 3'd0;
  localparam logic [2:0] ST_MOVE_TO_POSITION = 3'd1;
  localparam logic [2:0] ST_IN_POSITION      = 3'd2;
  localparam logic [2:0] ST_CAPTURING        = 3'd3;
  localparam logic [2:0] ST_CAPTURED         = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE             = ST_IDLE,
    S_MOVE_TO_POSITION = ST_MOVE_TO_POSITION,
    S_IN_POSITION      = ST_IN_POSITION,
    S_CAPTURING        = ST_CAPTURING,
    S_CAPTURED         = ST_CAPTURED
  } la_state_e;

  // Probe packing: larry occupies the LSBs, shemp the MSBs.
  localparam int LARRY_W = 1;
  localparam int CURLY_W = 1;
  localparam int MOE_W   = 1;
  localparam int SHEMP_W = 4;
  localparam int PROBES_W = LARRY_W + CURLY_W + MOE_W + SHEMP_W;

  typedef struct packed {
    logic [SHEMP_W-1:0] shemp;
    logic [MOE_W-1:0]   moe;
    logic [CURLY_W-1:0] curly;
    logic [LARRY_W-1:0] larry;
  } probes_t;

  function automatic logic state_writes(input la_state_e s);
    return (s == S_MOVE_TO_POSITION) || (s == S_IN_POSITION) || (s == S_CAPTURING);
  endfunction

endpackage

// File: rtl/logic_analyzer_capture_bram.sv
// Simple dual-port sample RAM: one write port, one registered read port, single clock.
// The array itself is never reset so it maps onto block RAM.
module capture_bram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; only the output register is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rdata <= {WIDTH{1'b0}};
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/logic_analyzer_capture.sv
// Capture core: records the probe bus into a circular buffer around a trigger and
// exposes the captured window oldest-first through a registered read port.
module logic_analyzer_capture
  import logic_analyzer_pkg::*;
#(
  parameter int SAMPLE_DEPTH      = 4096,
  parameter int TOTAL_PROBE_WIDTH = 7,
  parameter int TRIGGER_LOC       = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [TOTAL_PROBE_WIDTH-1:0]    probes,
  input  logic                            trigger,
  input  logic                            arm,
  input  logic                            stop,
  output logic [2:0]                      state,
  output logic                            done,
  input  logic [$clog2(SAMPLE_DEPTH)-1:0] rd_addr,
  output logic [TOTAL_PROBE_WIDTH-1:0]    rd_data
);

  localparam int AW = $clog2(SAMPLE_DEPTH);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] TL      = AW'(TRIGGER_LOC);
  localparam logic [AW-1:0] TL_LAST = AW'(TRIGGER_LOC - 1);

  la_state_e     r_state;
  la_state_e     w_state_nxt;
  logic [AW-1:0] r_write_ptr, w_write_ptr_nxt;
  logic [AW-1:0] r_base_ptr, w_base_ptr_nxt;
  logic [AW-1:0] r_count, w_count_nxt;
  logic          r_done;
  logic          w_we;
  logic [AW-1:0] w_ptr_inc;
  logic [AW-1:0] w_trig_base;
  logic [AW-1:0] w_rd_phys;

  assign w_we        = !stop && state_writes(r_state);
  assign w_ptr_inc   = r_write_ptr + ONE;
  assign w_trig_base = r_write_ptr - TL;
  assign w_rd_phys   = r_base_ptr + rd_addr;

  // Next-state and pointer update logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_write_ptr_nxt = r_write_ptr;
    w_base_ptr_nxt  = r_base_ptr;
    w_count_nxt     = r_count;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_CAPTURED: begin
          if (arm) begin
            w_write_ptr_nxt = {AW{1'b0}};
            w_count_nxt     = {AW{1'b0}};
            w_state_nxt     = (TRIGGER_LOC == 0) ? S_IN_POSITION : S_MOVE_TO_POSITION;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_MOVE_TO_POSITION: begin
          w_write_ptr_nxt = w_ptr_inc;
          w_count_nxt     = r_count + ONE;
          if (r_count == TL_LAST) begin
            w_state_nxt = S_IN_POSITION;
          end else begin
            w_state_nxt = S_MOVE_TO_POSITION;
          end
        end
        S_IN_POSITION: begin
          w_write_ptr_nxt = w_ptr_inc;
          if (trigger) begin
            w_base_ptr_nxt = w_trig_base;
            // With TRIGGER_LOC == SAMPLE_DEPTH-1 the trigger sample is also the last one.
            if (w_ptr_inc == w_trig_base) begin
              w_state_nxt = S_CAPTURED;
            end else begin
              w_state_nxt = S_CAPTURING;
            end
          end else begin
            w_state_nxt = S_IN_POSITION;
          end
        end
        S_CAPTURING: begin
          w_write_ptr_nxt = w_ptr_inc;
          if (w_ptr_inc == r_base_ptr) begin
            w_state_nxt = S_CAPTURED;
          end else begin
            w_state_nxt = S_CAPTURING;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, pointer and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_write_ptr <= {AW{1'b0}};
      r_base_ptr  <= {AW{1'b0}};
      r_count     <= {AW{1'b0}};
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_write_ptr <= w_write_ptr_nxt;
      r_base_ptr  <= w_base_ptr_nxt;
      r_count     <= w_count_nxt;
      r_done      <= (w_state_nxt == S_CAPTURED);
    end
  end

  assign state = r_state;
  assign done  = r_done;

  capture_bram #(
    .DEPTH(SAMPLE_DEPTH),
    .WIDTH(TOTAL_PROBE_WIDTH)
  ) u_bram (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(r_write_ptr),
    .i_wdata(probes),
    .i_raddr(w_rd_phys),
    .o_rdata(rd_data)
  );

endmodule

// File: tb/tb_logic_analyzer_capture.sv
// Bench for logic_analyzer_capture: three instances (TRIGGER_LOC 4, 0, 15) at depth 16,
// checked every cycle against a sample-history model plus directed literal expectations.
module tb_logic_analyzer_capture;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] probes = 7'd0;
  logic       arm [3];
  logic       stp [3];
  logic       trig [3];
  logic [3:0] rd_addr [3];
  logic [2:0] st [3];
  logic       dn [3];
  logic [6:0] rdd [3];

  int n_vec = 0;
  int n_err = 0;

  function automatic int tl_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 0 : 15);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic_analyzer_capture #(
      .SAMPLE_DEPTH(D),
      .TOTAL_PROBE_WIDTH(7),
      .TRIGGER_LOC(g == 0 ? 4 : (g == 1 ? 0 : 15))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .probes(probes), .trigger(trig[g]),
      .arm(arm[g]), .stop(stp[g]), .state(st[g]), .done(dn[g]),
      .rd_addr(rd_addr[g]), .rd_data(rdd[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Free-running probe counter, changed mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      probes = probes + 7'd1;
    end
  end

  // Model: phase 0 = idle, 1 = armed, 2 = captured; history of samples written since arm.
  int         phase [3] = '{0, 0, 0};
  int         nw [3] = '{0, 0, 0};
  int         trg [3] = '{-1, -1, -1};
  logic [6:0] hist [3][4096];
  logic [6:0] cap [3][16];
  int         pp [3];
  logic       m_a [3], m_s [3], m_t [3];
  logic [3:0] m_ra [3];
  logic       m_r;
  logic [6:0] m_p;

  function automatic int exp_state(input int g);
    if (phase[g] == 0) return 0;
    if (phase[g] == 2) return 4;
    if (nw[g] < tl_of(g)) return 1;
    if (trg[g] < 0) return 2;
    return 3;
  endfunction

  always begin
    @(posedge clk);
    m_r = rst_n;
    m_p = probes;
    for (int g = 0; g < 3; g++) begin
      m_a[g] = arm[g]; m_s[g] = stp[g]; m_t[g] = trig[g]; m_ra[g] = rd_addr[g];
      pp[g] = phase[g];
      if (!m_r || m_s[g]) begin
        phase[g] = 0;
      end else if (phase[g] != 1) begin
        if (m_a[g]) begin
          phase[g] = 1; nw[g] = 0; trg[g] = -1;
        end
      end else begin
        hist[g][nw[g] % 4096] = m_p;
        if (nw[g] >= tl_of(g) && trg[g] < 0 && m_t[g]) trg[g] = nw[g];
        nw[g]++;
        if (trg[g] >= 0 && nw[g] - trg[g] == D - tl_of(g)) begin
          phase[g] = 2;
          for (int i = 0; i < D; i++) cap[g][i] = hist[g][(trg[g] - tl_of(g) + i) % 4096];
        end
      end
    end
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("model_state%0d", g), int'(st[g]), exp_state(g));
      chk($sformatf("model_done%0d", g), int'(dn[g]), int'(exp_state(g) == 4));
      if (!m_r) chk($sformatf("rst_rd_data%0d", g), int'(rdd[g]), 0);
      else if (pp[g] == 2) chk($sformatf("model_rd_data%0d", g), int'(rdd[g]), int'(cap[g][m_ra[g]]));
    end
  end

  task automatic arm_it(input int g);
    @(negedge clk); arm[g] = 1'b1;
    @(negedge clk); arm[g] = 1'b0;
  endtask

  task automatic trig_pulse(input int g, output int pv);
    trig[g] = 1'b1; pv = int'(probes);
    @(negedge clk); trig[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (dn[g]) break;
    end
    chk($sformatf("done_reached%0d", g), int'(dn[g]), 1);
  endtask

  task automatic read_all(input int g, input int base, input string nm);
    for (int i = 0; i < D; i++) begin
      @(negedge clk); rd_addr[g] = 4'(i);
      @(posedge clk); #2;
      chk($sformatf("%s[%0d]", nm, i), int'(rdd[g]), (base + i) & 127);
    end
  endtask

  task automatic wait_probe(input int v);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (int'(probes) == v) break;
    end
    chk("wait_probe", int'(probes), v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pv;
    for (int g = 0; g < 3; g++) begin
      arm[g] = 1'b0; stp[g] = 1'b0; trig[g] = 1'b0; rd_addr[g] = 4'd0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // TL=4: arm at probe 10, trigger at probe 20.
    wait_probe(10);
    arm[0] = 1'b1;
    @(negedge clk); arm[0] = 1'b0;
    chk("s1_move_state", int'(st[0]), 1);
    wait_probe(20);
    trig[0] = 1'b1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #2;
      chk($sformatf("s1_state_e%0d", e), int'(st[0]), (e < 11) ? 3 : 4);
      chk($sformatf("s1_done_e%0d", e), int'(dn[0]), (e < 11) ? 0 : 1);
      @(negedge clk); trig[0] = 1'b0;
    end
    read_all(0, 16, "s1_rd");

    // TL=0: trigger held high from arm.
    @(negedge clk);
    arm[1] = 1'b1; trig[1] = 1'b1; pv = int'(probes);
    @(posedge clk); #2;
    chk("s2_in_position", int'(st[1]), 2);
    @(negedge clk); arm[1] = 1'b0;
    @(posedge clk); #2;
    chk("s2_capturing", int'(st[1]), 3);
    wait_done(1, 20);
    @(negedge clk); trig[1] = 1'b0;
    read_all(1, pv + 1, "s2_rd");

    // TL=4 re-armed from CAPTURED; pulse in MOVE_TO_POSITION ignored, second pulse wraps.
    arm_it(0);
    chk("s3_rearm_state", int'(st[0]), 1);
    @(negedge clk);
    trig_pulse(0, pv);
    repeat (29) @(negedge clk);
    trig_pulse(0, pv);
    wait_done(0, 20);
    read_all(0, pv - 4, "s3_rd");

    // stop mid-capture, then stop together with arm, then a normal capture.
    arm_it(0);
    repeat (5) @(negedge clk);
    trig_pulse(0, pv);
    repeat (3) @(negedge clk);
    stp[0] = 1'b1;
    @(posedge clk); #2;
    chk("s4_stop_state", int'(st[0]), 0);
    chk("s4_stop_done", int'(dn[0]), 0);
    @(negedge clk); arm[0] = 1'b1; stp[0] = 1'b1;
    @(posedge clk); #2;
    chk("s4_stoparm_state", int'(st[0]), 0);
    @(negedge clk); arm[0] = 1'b0; stp[0] = 1'b0;
    arm_it(0);
    repeat (5) @(negedge clk);
    trig_pulse(0, pv);
    wait_done(0, 20);
    read_all(0, pv - 4, "s4_rd");

    // Reset pulse during CAPTURING.
    arm_it(0);
    repeat (5) @(negedge clk);
    trig_pulse(0, pv);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("s5_rst_state%0d", g), int'(st[g]), 0);
      chk($sformatf("s5_rst_done%0d", g), int'(dn[g]), 0);
      chk($sformatf("s5_rst_rd%0d", g), int'(rdd[g]), 0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Capture, toggle trigger in CAPTURED, re-read, then re-arm.
    arm_it(0);
    repeat (6) @(negedge clk);
    trig_pulse(0, pv);
    wait_done(0, 20);
    read_all(0, pv - 4, "s6_rd_a");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); trig[0] = ~trig[0];
    end
    trig[0] = 1'b0;
    read_all(0, pv - 4, "s6_rd_b");
    arm_it(0);
    chk("s6_rearm_state", int'(st[0]), 1);
    @(negedge clk); stp[0] = 1'b1;
    @(negedge clk); stp[0] = 1'b0;

    // TL=15: single-sample capture goes IN_POSITION -> CAPTURED.
    arm_it(2);
    chk("s7_move_state", int'(st[2]), 1);
    repeat (15) @(negedge clk);
    chk("s7_in_position", int'(st[2]), 2);
    trig_pulse(2, pv);
    chk("s7_captured", int'(st[2]), 4);
    chk("s7_done", int'(dn[2]), 1);
    read_all(2, pv - 15, "s7_rd");

    // Random traffic on all instances, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        arm[g]     = ($urandom % 24) == 0;
        stp[g]     = ($urandom % 150) == 0;
        trig[g]    = ($urandom % 6) == 0;
        rd_addr[g] = 4'($urandom);
      end
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      arm[g] = 1'b0; stp[g] = 1'b0; trig[g] = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
